// File: rtl/led_div_pkg.sv
// ---------------------------------------------------------------------------
// led_div_pkg
//   Shared definitions for the LED divider slice.
//   - DEF_WIDTH / DEF_TWIDTH : default widths of the half-period and toggle
//                              counters
//   - DEF_HP                 : half-period that takes effect after reset
//   - hp_t                   : half-period value at the default width
//   - load_state_e           : state of the half-period load handshake
//   - hp_clamp()             : maps a half-period of 0 to 1
// ---------------------------------------------------------------------------
package led_div_pkg;

  localparam int DEF_WIDTH  = 8;
  localparam int DEF_TWIDTH = 16;
  localparam int DEF_HP     = 3;

  typedef logic [DEF_WIDTH-1:0] hp_t;

  // LD_IDLE: shadow register empty, a new half-period can be accepted.
  // LD_PENDING: a value waits in the shadow register for the next terminal.
  typedef enum logic {
    LD_IDLE    = 1'b0,
    LD_PENDING = 1'b1
  } load_state_e;

  // A half-period of zero cycles has no meaning; treat it as the fastest
  // legal rate instead of letting the counter compare underflow.
  function automatic hp_t hp_clamp(hp_t value);
    return (value == '0) ? hp_t'(1) : value;
  endfunction

endpackage

// File: rtl/div_counter.sv
// ---------------------------------------------------------------------------
// div_counter
//   Half-period counter for led_div. Counts enabled cycles from 0 up to
//   hp_i-1 and raises term_o combinationally in the enabled cycle where the
//   count reaches that terminal value; the count then restarts from 0.
//
//   Ports:
//     clk    in   system clock, rising edge
//     rst_n  in   synchronous active-low reset (count returns to 0)
//     en_i   in   count enable; when low the count holds and term_o is 0
//     hp_i   in   half-period in effect, always >= 1
//     term_o out  terminal strobe, valid in the cycle before the edge that
//                 wraps the count
// ---------------------------------------------------------------------------
module div_counter
  import led_div_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic [WIDTH-1:0] hp_i,
  output logic             term_o
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  // The terminal compare uses the half-period currently in effect; a new
  // value only reaches hp_i at a terminal, so the compare never sees a
  // half-period change partway through a count.
  assign term_o = en_i && (cnt_q == (hp_i - WIDTH'(1)));

  // Next-count logic: hold when disabled, wrap on terminal, otherwise step.
  always_comb begin
    cnt_d = cnt_q;
    if (en_i) begin
      if (term_o) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + WIDTH'(1);
      end
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/led_div.sv
// ---------------------------------------------------------------------------
// led_div
//   Programmable clock divider / LED blinker. Produces a 50% duty square wave
//   on led with a half-period of hp enabled cycles, a registered one-cycle
//   tick for every led transition, and a wrapping count of transitions. The
//   half-period can be reprogrammed through a valid/ready port; the new value
//   waits in a shadow register and is applied only at the end of the
//   half-period in progress, so the output never shows a runt pulse.
//
//   Ports:
//     clk         in   system clock, rising edge
//     rst_n       in   synchronous active-low reset
//     en          in   count enable; when low everything but the load
//                      handshake freezes
//     load_valid  in   a new half-period is offered on load_hp
//     load_hp     in   offered half-period, 0 is treated as 1
//     load_ready  out  shadow register is free
//     led         out  divided square wave
//     tick        out  one-cycle pulse in the cycle led changes
//     toggles     out  led transitions since reset, wraps
//     hp          out  half-period currently in effect
// ---------------------------------------------------------------------------
module led_div
  import led_div_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int DEFAULT_HP = DEF_HP,
  parameter int TWIDTH     = DEF_TWIDTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              load_valid,
  input  logic [WIDTH-1:0]  load_hp,
  output logic              load_ready,
  output logic              led,
  output logic              tick,
  output logic [TWIDTH-1:0] toggles,
  output logic [WIDTH-1:0]  hp
);

  load_state_e       state_q, state_d;
  logic [WIDTH-1:0]  hp_q, hp_d;
  logic [WIDTH-1:0]  pendHp_q, pendHp_d;
  logic              led_q, led_d;
  logic              tick_q, tick_d;
  logic [TWIDTH-1:0] toggles_q, toggles_d;

  logic              term;
  logic              loadFire;
  logic [WIDTH-1:0]  loadHpClamped;

  // The package helper works at the default width; any other width uses an
  // equivalent local compare so the clamp never truncates the offered value.
  generate
    if (WIDTH == DEF_WIDTH) begin : g_pkg_clamp
      assign loadHpClamped = hp_clamp(load_hp);
    end else begin : g_local_clamp
      assign loadHpClamped = (load_hp == '0) ? WIDTH'(1) : load_hp;
    end
  endgenerate

  div_counter #(
    .WIDTH (WIDTH)
  ) u_counter (
    .clk    (clk),
    .rst_n  (rst_n),
    .en_i   (en),
    .hp_i   (hp_q),
    .term_o (term)
  );

  // Only one value can wait at a time, so ready simply reflects an empty
  // shadow register. A held load_valid is therefore taken once and then
  // blocked until the pending value has been applied.
  assign load_ready = (state_q == LD_IDLE);
  assign loadFire   = load_valid && load_ready;

  // Next-state logic. The terminal consumes whatever was pending before this
  // edge; a handshake landing on the same edge only fills the shadow register
  // and waits for the following terminal. Because a handshake requires the
  // idle state, the two updates of state_d never compete for a value.
  always_comb begin
    state_d   = state_q;
    hp_d      = hp_q;
    pendHp_d  = pendHp_q;
    led_d     = led_q;
    tick_d    = 1'b0;
    toggles_d = toggles_q;

    if (term) begin
      led_d     = !led_q;
      tick_d    = 1'b1;
      toggles_d = toggles_q + TWIDTH'(1);
      if (state_q == LD_PENDING) begin
        hp_d    = pendHp_q;
        state_d = LD_IDLE;
      end
    end

    if (loadFire) begin
      pendHp_d = loadHpClamped;
      state_d  = LD_PENDING;
    end
  end

  // State registers. Reset drops any pending value along with the count so
  // the block restarts from the default half-period.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= LD_IDLE;
      hp_q      <= WIDTH'(DEFAULT_HP);
      pendHp_q  <= '0;
      led_q     <= 1'b0;
      tick_q    <= 1'b0;
      toggles_q <= '0;
    end else begin
      state_q   <= state_d;
      hp_q      <= hp_d;
      pendHp_q  <= pendHp_d;
      led_q     <= led_d;
      tick_q    <= tick_d;
      toggles_q <= toggles_d;
    end
  end

  assign led     = led_q;
  assign tick    = tick_q;
  assign toggles = toggles_q;
  assign hp      = hp_q;

endmodule

// File: tb/tb_led_div.sv
// ---------------------------------------------------------------------------
// tb_led_div
//   Self-checking bench for led_div. A behavioural model counts down the
//   cycles remaining in the current half-period and is compared against the
//   DUT after every edge, alongside fixed expectations for the directed
//   scenarios.
// ---------------------------------------------------------------------------
module tb_led_div;

  localparam int W   = 8;
  localparam int TW  = 16;
  localparam int DHP = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic          load_valid;
  logic [W-1:0]  load_hp;
  logic          load_ready;
  logic          led;
  logic          tick;
  logic [TW-1:0] toggles;
  logic [W-1:0]  hp;

  int checkCount  = 0;
  int errorCount  = 0;
  bit checkEnable = 1'b1;

  // Reference model state
  bit mLed;
  bit mTick;
  bit mPend;
  int mToggles;
  int mHp;
  int mPendHp;
  int mRem;

  led_div #(
    .WIDTH      (W),
    .DEFAULT_HP (DHP),
    .TWIDTH     (TW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .load_valid (load_valid),
    .load_hp    (load_hp),
    .load_ready (load_ready),
    .led        (led),
    .tick       (tick),
    .toggles    (toggles),
    .hp         (hp)
  );

  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Behavioural model: each enabled cycle uses up one cycle of the current
  // half-period; when the last one is used led flips and any waiting value
  // becomes the new half-period. A handshake only fills the waiting slot.
  task automatic modelStep(input bit r, input bit e, input bit v, input int h);
    bit accepted;
    if (!r) begin
      mLed = 0; mTick = 0; mToggles = 0; mHp = DHP;
      mPend = 0; mPendHp = 0; mRem = DHP;
      return;
    end
    accepted = v && !mPend;
    mTick = 0;
    if (e) begin
      if (mRem == 1) begin
        mLed = !mLed;
        mTick = 1;
        mToggles = (mToggles + 1) % (1 << TW);
        if (mPend) begin
          mHp = mPendHp;
          mPend = 0;
        end
        mRem = mHp;
      end else begin
        mRem = mRem - 1;
      end
    end
    if (accepted) begin
      mPend = 1;
      mPendHp = (h == 0) ? 1 : h;
    end
  endtask

  task automatic checkModel(input string where);
    checkOutput($sformatf("%s.led", where), led, mLed);
    checkOutput($sformatf("%s.tick", where), tick, mTick);
    checkOutput($sformatf("%s.toggles", where), toggles, mToggles);
    checkOutput($sformatf("%s.hp", where), hp, mHp);
    checkOutput($sformatf("%s.ready", where), load_ready, !mPend);
  endtask

  // Drives one cycle of inputs, advances the model on the edge and compares
  // shortly after it.
  task automatic applyStimulus(input string where, input bit r, input bit e,
                               input bit v, input int h);
    rst_n      = r;
    en         = e;
    load_valid = v;
    load_hp    = h[W-1:0];
    @(posedge clk);
    modelStep(r, e, v, h);
    #1;
    if (checkEnable) checkModel(where);
  endtask

  task automatic checkResetValues(input string where);
    checkOutput($sformatf("%s.rst.led", where), led, 0);
    checkOutput($sformatf("%s.rst.tick", where), tick, 0);
    checkOutput($sformatf("%s.rst.toggles", where), toggles, 0);
    checkOutput($sformatf("%s.rst.hp", where), hp, DHP);
    checkOutput($sformatf("%s.rst.ready", where), load_ready, 1);
  endtask

  // Default-rate run: led toggles every third cycle after release.
  task automatic runDefaultSequence(input string where);
    for (int k = 1; k <= 20; k++) begin
      applyStimulus(where, 1, 1, 0, 0);
      checkOutput($sformatf("%s.tick%0d", where, k), tick, (k % 3 == 0));
      if (k == 18) checkOutput($sformatf("%s.toggles18", where), toggles, 6);
    end
  endtask

  initial begin
    bit sLed;
    int sTog;
    bit prevLed;
    rst_n = 1'b0; en = 1'b0; load_valid = 1'b0; load_hp = '0;

    // Scenario 1: reset values and default half-period
    applyStimulus("s1", 0, 0, 0, 0);
    checkResetValues("s1");
    runDefaultSequence("s1");

    // Scenario 2: load 5 just after a terminal
    applyStimulus("s2", 0, 0, 0, 0);
    for (int k = 1; k <= 17; k++) begin
      applyStimulus("s2", 1, 1, (k == 4), 5);
      checkOutput($sformatf("s2.tick%0d", k), tick,
                  (k == 3 || k == 6 || k == 11 || k == 16));
      if (k == 4 || k == 5) checkOutput("s2.readyLow", load_ready, 0);
      if (k == 5) checkOutput("s2.hpOld", hp, 3);
      if (k == 6) checkOutput("s2.hpNew", hp, 5);
      if (k == 6) checkOutput("s2.readyBack", load_ready, 1);
    end

    // Scenario 3: handshake on the same edge as a terminal
    applyStimulus("s3", 0, 0, 0, 0);
    for (int k = 1; k <= 12; k++) begin
      applyStimulus("s3", 1, 1, (k == 3), 2);
      checkOutput($sformatf("s3.tick%0d", k), tick,
                  (k == 3 || k == 6 || k == 8 || k == 10 || k == 12));
      if (k == 3) checkOutput("s3.hpHeld", hp, 3);
      if (k == 6) checkOutput("s3.hpNew", hp, 2);
    end

    // Scenario 4: load 0 clamps to 1, led toggles every enabled cycle
    applyStimulus("s4", 1, 1, 1, 0);
    prevLed = mLed;
    for (int k = 1; k <= 10; k++) begin
      applyStimulus("s4", 1, 1, 0, 0);
      if (k >= 5) begin
        checkOutput("s4.hp", hp, 1);
        checkOutput("s4.tickHeld", tick, 1);
        checkOutput("s4.ledFlip", led, !prevLed);
      end
      prevLed = mLed;
    end

    // Scenario 5: freeze with en low, then load while frozen
    applyStimulus("s5", 1, 1, 1, 4);
    for (int k = 0; k < 6; k++) applyStimulus("s5", 1, 1, 0, 0);
    sLed = mLed;
    sTog = mToggles;
    for (int k = 0; k < 4; k++) begin
      applyStimulus("s5.frz", 1, 0, 0, 0);
      checkOutput("s5.frzLed", led, sLed);
      checkOutput("s5.frzToggles", toggles, sTog);
      checkOutput("s5.frzTick", tick, 0);
    end
    applyStimulus("s5.ld", 1, 0, 1, 6);
    checkOutput("s5.ldReady", load_ready, 0);
    checkOutput("s5.ldHp", hp, 4);
    checkOutput("s5.ldLed", led, sLed);
    for (int k = 0; k < 12; k++) applyStimulus("s5.run", 1, 1, 0, 0);
    checkOutput("s5.hpApplied", hp, 6);

    // Random phase against the model
    for (int k = 0; k < 400; k++) begin
      applyStimulus("rnd", ($urandom_range(0, 99) != 0), ($urandom_range(0, 3) != 0),
                    ($urandom_range(0, 4) == 0), $urandom_range(0, 6));
    end

    // Wrap preload: hp=1 until toggles reaches 0xFFFF
    applyStimulus("wr", 0, 0, 0, 0);
    applyStimulus("wr", 1, 1, 1, 0);
    checkEnable = 1'b0;
    for (int i = 0; i < 70000 && mToggles != 16'hFFFF; i++) begin
      applyStimulus("wr", 1, 1, 0, 0);
    end
    checkEnable = 1'b1;
    checkOutput("wr.toggles", toggles, 16'hFFFF);
    checkModel("wr");
    applyStimulus("wr.pend", 1, 0, 1, 7);
    checkOutput("wr.pendReady", load_ready, 0);
    checkOutput("wr.pendToggles", toggles, 16'hFFFF);

    // Reset with a pending value: everything restarts as in scenario 1
    applyStimulus("rr", 0, 1, 0, 0);
    checkResetValues("rr");
    runDefaultSequence("rr");
    checkOutput("rr.hpKept", hp, DHP);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
